// File: rtl/mmss_timer.sv
// MM:SS countdown/stopwatch with tick prescaler, preset saturation and
// active-low 7-segment decode of all four BCD digits.
//
//  state | meaning
//  ------+-----------------------------------------------------------
//  IDLE  | preset loaded (or after reset), waiting for run
//  RUN   | prescaler counting, value stepped once per tick
//  PAUSE | run dropped; value and prescaler both held
//  DONE  | terminal value reached; frozen until load or reset
module mmss_timer #(
    parameter int TICK_DIV = 50000000,
    parameter int MAX_MINS = 99
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [6:0] preset_min,
    input  logic [5:0] preset_sec,
    input  logic       run,
    input  logic       mode,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic [6:0] HEX3,
    output logic [6:0] HEX2,
    output logic [6:0] HEX1,
    output logic [6:0] HEX0,
    output logic       running,
    output logic       done,
    output logic       done_pulse
);

    localparam int              PW       = $clog2(TICK_DIV);
    localparam logic [PW-1:0]   PRE_LAST = PW'(TICK_DIV - 1);
    localparam logic [3:0]      MAX_T    = 4'(MAX_MINS / 10);
    localparam logic [3:0]      MAX_O    = 4'(MAX_MINS % 10);
    localparam logic [15:0]     TERM_UP  = {MAX_T, MAX_O, 4'd5, 4'd9};
    localparam logic [15:0]     TERM_DN  = 16'h0000;

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

    state_t        state, state_n;
    logic [PW-1:0] pre, pre_n;
    logic [15:0]   val, val_n, val_inc, val_dec, val_step, preset_bcd;
    logic [6:0]    min_sat;
    logic [5:0]    sec_sat;
    logic          tick, at_term, step_term;

    // Binary (0..99) to two BCD digits by repeated subtraction.
    function automatic logic [7:0] to_bcd(input logic [6:0] v);
        logic [3:0] t;
        logic [3:0] o;
        logic [6:0] r;
        t = 4'd0;
        o = 4'd0;
        r = v;
        for (int i = 0; i < 9; i++) begin
            if (r >= 7'd10) begin
                r = r - 7'd10;
                t = t + 4'd1;
            end
        end
        for (int k = 0; k < 10; k++) begin
            if (r == 7'(k)) o = 4'(k);
        end
        return {t, o};
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    always_comb begin
        min_sat    = (preset_min > 7'(MAX_MINS)) ? 7'(MAX_MINS) : preset_min;
        sec_sat    = (preset_sec > 6'd59) ? 6'd59 : preset_sec;
        preset_bcd = {to_bcd(min_sat), to_bcd({1'b0, sec_sat})};
    end

    always_comb begin
        val_inc = val;
        if (val[3:0] != 4'd9) begin
            val_inc[3:0] = val[3:0] + 4'd1;
        end else begin
            val_inc[3:0] = 4'd0;
            if (val[7:4] != 4'd5) begin
                val_inc[7:4] = val[7:4] + 4'd1;
            end else begin
                val_inc[7:4] = 4'd0;
                if (val[11:8] != 4'd9) begin
                    val_inc[11:8] = val[11:8] + 4'd1;
                end else begin
                    val_inc[11:8]  = 4'd0;
                    val_inc[15:12] = val[15:12] + 4'd1;
                end
            end
        end
    end

    always_comb begin
        val_dec = val;
        if (val[3:0] != 4'd0) begin
            val_dec[3:0] = val[3:0] - 4'd1;
        end else begin
            val_dec[3:0] = 4'd9;
            if (val[7:4] != 4'd0) begin
                val_dec[7:4] = val[7:4] - 4'd1;
            end else begin
                val_dec[7:4] = 4'd5;
                if (val[11:8] != 4'd0) begin
                    val_dec[11:8] = val[11:8] - 4'd1;
                end else begin
                    val_dec[11:8]  = 4'd9;
                    val_dec[15:12] = val[15:12] - 4'd1;
                end
            end
        end
    end

    // Terminal test uses the mode of this cycle so a mid-run mode change
    // only affects the next step.
    assign val_step  = mode ? val_inc : val_dec;
    assign at_term   = mode ? (val == TERM_UP) : (val == TERM_DN);
    assign step_term = mode ? (val_step == TERM_UP) : (val_step == TERM_DN);
    assign tick      = (pre == PRE_LAST);

    always_comb begin
        state_n = state;
        pre_n   = pre;
        val_n   = val;
        if (load) begin
            state_n = IDLE;
            pre_n   = '0;
            val_n   = preset_bcd;
        end else begin
            case (state)
                IDLE, PAUSE: begin
                    if (run) state_n = RUN;
                end
                RUN: begin
                    if (!run) begin
                        state_n = PAUSE;
                    end else if (at_term) begin
                        state_n = DONE;
                    end else if (tick) begin
                        pre_n = '0;
                        val_n = val_step;
                        if (step_term) state_n = DONE;
                    end else begin
                        pre_n = pre + PW'(1);
                    end
                end
                DONE: ;
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            pre        <= '0;
            val        <= '0;
            done_pulse <= 1'b0;
        end else begin
            state      <= state_n;
            pre        <= pre_n;
            val        <= val_n;
            done_pulse <= (state_n == DONE) && (state != DONE);
        end
    end

    assign {min_tens, min_ones, sec_tens, sec_ones} = val;
    assign HEX3    = seg7(min_tens);
    assign HEX2    = seg7(min_ones);
    assign HEX1    = seg7(sec_tens);
    assign HEX0    = seg7(sec_ones);
    assign running = (state == RUN);
    assign done    = (state == DONE);

endmodule

// File: tb/tb_mmss_timer.sv
// Scoreboard bench for mmss_timer: directed stimulus queues expected output
// changes with their cycle stamps; a negedge monitor matches every change.
module tb_mmss_timer;

    typedef struct packed {
        logic [31:0] cyc;
        logic [15:0] val;
        logic        r;
        logic        d;
        logic        p;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       la = 1'b0, ra = 1'b0, ma = 1'b0;
    logic       lb = 1'b0, rb = 1'b0, mb = 1'b0;
    logic [6:0] pma = '0, pmb = '0;
    logic [5:0] psa = '0, psb = '0;

    logic [3:0] a_mt, a_mo, a_st, a_so, b_mt, b_mo, b_st, b_so;
    logic [6:0] a_h3, a_h2, a_h1, a_h0, b_h3, b_h2, b_h1, b_h0;
    logic       a_run, a_done, a_pulse, b_run, b_done, b_pulse;

    int         cyc = 0;
    int         n_checks = 0;
    int         n_pass = 0;
    exp_t       qa[$];
    exp_t       qb[$];
    logic [18:0] prev_a = '0;
    logic [18:0] prev_b = '0;

    mmss_timer #(.TICK_DIV(4), .MAX_MINS(99)) dut_a (
        .clk(clk), .reset(reset), .load(la), .preset_min(pma), .preset_sec(psa),
        .run(ra), .mode(ma),
        .min_tens(a_mt), .min_ones(a_mo), .sec_tens(a_st), .sec_ones(a_so),
        .HEX3(a_h3), .HEX2(a_h2), .HEX1(a_h1), .HEX0(a_h0),
        .running(a_run), .done(a_done), .done_pulse(a_pulse)
    );

    mmss_timer #(.TICK_DIV(4), .MAX_MINS(1)) dut_b (
        .clk(clk), .reset(reset), .load(lb), .preset_min(pmb), .preset_sec(psb),
        .run(rb), .mode(mb),
        .min_tens(b_mt), .min_ones(b_mo), .sec_tens(b_st), .sec_ones(b_so),
        .HEX3(b_h3), .HEX2(b_h2), .HEX1(b_h1), .HEX0(b_h0),
        .running(b_run), .done(b_done), .done_pulse(b_pulse)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [6:0] seg(input logic [3:0] d);
        case (d)
            4'd0: return 7'b1000000;
            4'd1: return 7'b1111001;
            4'd2: return 7'b0100100;
            4'd3: return 7'b0110000;
            4'd4: return 7'b0011001;
            4'd5: return 7'b0010010;
            4'd6: return 7'b0000010;
            4'd7: return 7'b1111000;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    task automatic check(input string nm, input logic ok, input logic [63:0] got,
                         input logic [63:0] want);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s got=%0h want=%0h", nm, got, want);
    endtask

    task automatic ex(input int id, input int c, input logic [15:0] v,
                      input logic r, input logic d, input logic p);
        exp_t e;
        e = {32'(c), v, r, d, p};
        if (id == 0) qa.push_back(e);
        else qb.push_back(e);
    endtask

    task automatic mon_ev(input int id, input logic [18:0] s, input logic [27:0] hx);
        exp_t e;
        logic have;
        logic [27:0] hx_exp;
        have = 1'b0;
        e = '0;
        if (id == 0 && qa.size() > 0) begin
            e = qa.pop_front();
            have = 1'b1;
        end else if (id == 1 && qb.size() > 0) begin
            e = qb.pop_front();
            have = 1'b1;
        end
        if (!have) begin
            check($sformatf("unexpected_change_%0d@%0d", id, cyc), 1'b0, 64'(s), 64'(0));
        end else begin
            hx_exp = {seg(e.val[15:12]), seg(e.val[11:8]), seg(e.val[7:4]), seg(e.val[3:0])};
            check($sformatf("val_%0d@%0d", id, cyc), s === {e.val, e.r, e.d, e.p},
                  64'(s), 64'({e.val, e.r, e.d, e.p}));
            check($sformatf("cycle_%0d_val%0h", id, e.val), cyc == int'(e.cyc),
                  64'(cyc), 64'(e.cyc));
            check($sformatf("hex_%0d@%0d", id, cyc), hx === hx_exp, 64'(hx), 64'(hx_exp));
        end
    endtask

    always @(negedge clk) begin
        logic [18:0] sa, sb;
        sa = {a_mt, a_mo, a_st, a_so, a_run, a_done, a_pulse};
        sb = {b_mt, b_mo, b_st, b_so, b_run, b_done, b_pulse};
        if (sa !== prev_a) begin
            mon_ev(0, sa, {a_h3, a_h2, a_h1, a_h0});
            prev_a = sa;
        end
        if (sb !== prev_b) begin
            mon_ev(1, sb, {b_h3, b_h2, b_h1, b_h0});
            prev_b = sb;
        end
    end

    task automatic wait_to(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_digits"}, {a_mt, a_mo, a_st, a_so} === 16'h0000,
              64'({a_mt, a_mo, a_st, a_so}), 64'h0);
        check({tag, "_hex"}, {a_h3, a_h2, a_h1, a_h0} === {4{7'b1000000}},
              64'({a_h3, a_h2, a_h1, a_h0}), 64'({4{7'b1000000}}));
        check({tag, "_flags"}, {a_run, a_done, a_pulse} === 3'b000,
              64'({a_run, a_done, a_pulse}), 64'h0);
    endtask

    initial begin
        int c;
        logic [7:0] sb;

        #1 reset = 1'b1;
        #1 check_reset_outputs("por");
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // load 1:02 down with run held high; pause/resume; load on a tick edge
        c = cyc;
        la = 1; pma = 7'd1; psa = 6'd2; ma = 0; ra = 1;
        ex(0, c+1,  16'h0102, 0, 0, 0);
        ex(0, c+2,  16'h0102, 1, 0, 0);
        ex(0, c+6,  16'h0101, 1, 0, 0);
        ex(0, c+10, 16'h0100, 1, 0, 0);
        ex(0, c+14, 16'h0059, 1, 0, 0);
        @(negedge clk); la = 0;
        wait_to(c+16); ra = 0;
        ex(0, c+17, 16'h0059, 0, 0, 0);
        wait_to(c+20); ra = 1;
        ex(0, c+21, 16'h0059, 1, 0, 0);
        ex(0, c+23, 16'h0058, 1, 0, 0);
        wait_to(c+26); la = 1; pma = 7'd0; psa = 6'd38;
        ex(0, c+27, 16'h0038, 0, 0, 0);
        ex(0, c+28, 16'h0038, 1, 0, 0);
        ex(0, c+32, 16'h0037, 1, 0, 0);
        wait_to(c+27); la = 0;
        wait_to(c+32);

        // async reset in the middle of a second
        @(posedge clk); #2;
        ex(0, cyc, 16'h0000, 0, 0, 0);
        reset = 1'b1;
        #1 check_reset_outputs("midrun_rst");
        @(negedge clk); @(negedge clk);
        reset = 1'b0; ra = 0;
        @(negedge clk);

        // 0:02 down to done, then hold and ignore run
        c = cyc;
        la = 1; pma = 7'd0; psa = 6'd2; ma = 0; ra = 1;
        ex(0, c+1,  16'h0002, 0, 0, 0);
        ex(0, c+2,  16'h0002, 1, 0, 0);
        ex(0, c+6,  16'h0001, 1, 0, 0);
        ex(0, c+10, 16'h0000, 0, 1, 1);
        ex(0, c+11, 16'h0000, 0, 1, 0);
        @(negedge clk); la = 0;
        wait_to(c+20); ra = 0;
        wait_to(c+22); ra = 1;
        wait_to(c+26);

        // run from 0:00 counting down -> done on the next edge
        c = cyc;
        la = 1; pma = 7'd0; psa = 6'd0; ra = 1;
        ex(0, c+1, 16'h0000, 0, 0, 0);
        ex(0, c+2, 16'h0000, 1, 0, 0);
        ex(0, c+3, 16'h0000, 0, 1, 1);
        ex(0, c+4, 16'h0000, 0, 1, 0);
        @(negedge clk); la = 0;
        wait_to(c+8);

        // seconds saturate at 59
        c = cyc;
        la = 1; pma = 7'd5; psa = 6'd63; ra = 0;
        ex(0, c+1, 16'h0559, 0, 0, 0);
        @(negedge clk); la = 0;
        wait_to(c+3);

        // minutes saturate at 99; count up from 99:59 is already terminal
        c = cyc;
        la = 1; pma = 7'd120; psa = 6'd59;
        ex(0, c+1, 16'h9959, 0, 0, 0);
        @(negedge clk); la = 0; ma = 1; ra = 1;
        ex(0, c+2, 16'h9959, 1, 0, 0);
        ex(0, c+3, 16'h9959, 0, 1, 1);
        ex(0, c+4, 16'h9959, 0, 1, 0);
        wait_to(c+6);

        // borrow through minute tens, then load on the next edge after a tick
        c = cyc;
        la = 1; pma = 7'd10; psa = 6'd0; ma = 0; ra = 1;
        ex(0, c+1, 16'h1000, 0, 0, 0);
        ex(0, c+2, 16'h1000, 1, 0, 0);
        ex(0, c+6, 16'h0959, 1, 0, 0);
        @(negedge clk); la = 0;
        wait_to(c+6); la = 1; pma = 7'd0; psa = 6'd0; ra = 0;
        ex(0, c+7, 16'h0000, 0, 0, 0);
        @(negedge clk); la = 0;
        wait_to(c+9);

        // mode flipped mid-run only changes the following tick
        c = cyc;
        la = 1; pma = 7'd0; psa = 6'd5; ma = 0; ra = 1;
        ex(0, c+1,  16'h0005, 0, 0, 0);
        ex(0, c+2,  16'h0005, 1, 0, 0);
        ex(0, c+6,  16'h0004, 1, 0, 0);
        ex(0, c+10, 16'h0005, 1, 0, 0);
        @(negedge clk); la = 0;
        wait_to(c+7); ma = 1;
        wait_to(c+10); la = 1; psa = 6'd0; ra = 0;
        ex(0, c+11, 16'h0000, 0, 0, 0);
        @(negedge clk); la = 0;
        wait_to(c+13);

        // MAX_MINS=1 instance: count up 0:58 .. 1:59 then done
        c = cyc;
        lb = 1; pmb = 7'd0; psb = 6'd58; mb = 1; rb = 1;
        ex(1, c+1, 16'h0058, 0, 0, 0);
        ex(1, c+2, 16'h0058, 1, 0, 0);
        ex(1, c+6, 16'h0059, 1, 0, 0);
        for (int s = 0; s < 59; s++) begin
            sb = {4'(s / 10), 4'(s % 10)};
            ex(1, c + 10 + 4*s, {8'h01, sb}, 1, 0, 0);
        end
        ex(1, c+246, 16'h0159, 0, 1, 1);
        ex(1, c+247, 16'h0159, 0, 1, 0);
        @(negedge clk); lb = 0;
        wait_to(c+250);
        lb = 1; pmb = 7'd120; psb = 6'd0; rb = 0; mb = 0;
        ex(1, c+251, 16'h0100, 0, 0, 0);
        @(negedge clk); lb = 0;
        wait_to(c+256);

        check("pending_a", qa.size() == 0, 64'(qa.size()), 64'h0);
        check("pending_b", qb.size() == 0, 64'(qb.size()), 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
